rf_store_unit: RTL

//  Store-back path for the processor datapath: copies a block of register_file entries into

---
 rtl/rf_store_unit_pkg.sv | 16 +
 rtl/rf_store_unit.sv | 125 ++++++++++++
 2 files changed

// File: rtl/rf_store_unit_pkg.sv
// Shared definitions for the register-file to data-memory store-back unit.
// The processor side uses the same state encoding when it observes the unit.
package rf_store_unit_pkg;

    localparam int DEF_WORDSIZE = 64;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DEPTH    = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/rf_store_unit.sv
// Store-back sequencer: copies a block of register_file words into data_memory.
// Each word takes one READ cycle (RF read address presented, data captured)
// and one WRITE cycle (DM address/data/strobe presented). All outputs are registered.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | waiting for start; request fields latched on acceptance
// ST_READ   | rf_addr valid, rf_data captured at the end of the cycle
// ST_WRITE  | dm_write_enable high with captured word; advance or finish
// ST_FINISH | one-cycle done pulse, busy already low
module rf_store_unit
    import rf_store_unit_pkg::*;
#(
    parameter int WORDSIZE = DEF_WORDSIZE,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = DEF_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   rf_base,
    input  logic [ADDR_W-1:0]   dm_base,
    input  logic [ADDR_W:0]     count,
    output logic [ADDR_W-1:0]   rf_addr,
    input  logic [WORDSIZE-1:0] rf_data,
    output logic [ADDR_W-1:0]   dm_addr,
    output logic [WORDSIZE-1:0] dm_data_input,
    output logic                dm_write_enable,
    output logic                dm_read,
    output logic                busy,
    output logic                done
);

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] rf_start;
    logic [ADDR_W-1:0] dm_start;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   count_clamped;
    logic [ADDR_W-1:0] idx_next;
    logic              last_word;

    // Request length clamp and index bookkeeping; addresses wrap by plain
    // ADDR_W-bit truncation since DEPTH is a power of two equal to 2**ADDR_W.
    always_comb begin
        count_clamped = (count > DEPTH_L) ? DEPTH_L : count;
        idx_next      = idx + IDX_ONE;
        last_word     = ({1'b0, idx} == (len - LEN_ONE));
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            rf_start        <= '0;
            dm_start        <= '0;
            idx             <= '0;
            len             <= '0;
            rf_addr         <= '0;
            dm_addr         <= '0;
            dm_data_input   <= '0;
            dm_write_enable <= 1'b0;
            dm_read         <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            dm_read <= 1'b0;
            case (state)
                ST_IDLE: begin
                    done            <= 1'b0;
                    dm_write_enable <= 1'b0;
                    if (start) begin
                        rf_start <= rf_base;
                        dm_start <= dm_base;
                        len      <= count_clamped;
                        idx      <= '0;
                        if (count_clamped == '0) begin
                            // Empty request goes straight to the done pulse.
                            state <= ST_FINISH;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state   <= ST_READ;
                            busy    <= 1'b1;
                            rf_addr <= rf_base;
                        end
                    end
                end
                ST_READ: begin
                    dm_addr         <= dm_start + idx;
                    dm_data_input   <= rf_data;
                    dm_write_enable <= 1'b1;
                    state           <= ST_WRITE;
                end
                ST_WRITE: begin
                    dm_write_enable <= 1'b0;
                    if (last_word) begin
                        state <= ST_FINISH;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        idx     <= idx_next;
                        rf_addr <= rf_start + idx_next;
                        state   <= ST_READ;
                    end
                end
                ST_FINISH: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state           <= ST_IDLE;
                    dm_write_enable <= 1'b0;
                    busy            <= 1'b0;
                    done            <= 1'b0;
                end
            endcase
        end
    end

endmodule
